mem_wb_stage: RTL and testbench

- Pipeline register between the memory stage and the register file write port.
- Captures memory-stage results and performs load byte/halfword selection and sign/zero extension.
- Muxes the writeback source and drives the register file's wr_en/wr_addr/wr_data.
- Handles stall and flush (bubble insertion).

---
 rtl/mem_wb_stage.sv | 132 +++++++++++++
 tb/tb_mem_wb_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : MEM/WB pipeline register with load extraction/extension and
//            writeback source mux feeding the register file write port.
//            Define MEM_WB_RETIRE_CNT_EN to add the 64-bit instret counter.
// Revision : 1.0  initial release
// ============================================================================
module mem_wb_stage #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall_w,
   input  logic                  flush_w,
   input  logic                  valid_m,
   input  logic                  reg_write_m,
   input  logic [4:0]            rd_m,
   input  logic [1:0]            result_src_m,
   input  logic [2:0]            funct3_m,
   input  logic [DATA_WIDTH-1:0] alu_result_m,
   input  logic [DATA_WIDTH-1:0] read_data_m,
   input  logic [DATA_WIDTH-1:0] pc_plus4_m,
   input  logic [DATA_WIDTH-1:0] imm_ext_m,
   output logic                  valid_w,
   output logic                  wr_en,
   output logic [4:0]            wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data
`ifdef MEM_WB_RETIRE_CNT_EN
   ,
   output logic [63:0]           instret
`endif
);

   localparam logic [1:0] c_SRC_ALU  = 2'b00;
   localparam logic [1:0] c_SRC_LOAD = 2'b01;
   localparam logic [1:0] c_SRC_PC4  = 2'b10;

   logic                  r_valid_w;
   logic                  r_reg_write_w;
   logic [4:0]            r_rd_w;
   logic [1:0]            r_result_src_w;
   logic [2:0]            r_funct3_w;
   logic [DATA_WIDTH-1:0] r_alu_result_w;
   logic [DATA_WIDTH-1:0] r_read_data_w;
   logic [DATA_WIDTH-1:0] r_pc_plus4_w;
   logic [DATA_WIDTH-1:0] r_imm_ext_w;

   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [DATA_WIDTH-1:0] w_load_value;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid_w      <= 1'b0;
         r_reg_write_w  <= 1'b0;
         r_rd_w         <= '0;
         r_result_src_w <= '0;
         r_funct3_w     <= '0;
         r_alu_result_w <= '0;
         r_read_data_w  <= '0;
         r_pc_plus4_w   <= '0;
         r_imm_ext_w    <= '0;
      end else if (flush_w) begin
         r_valid_w      <= 1'b0;
         r_reg_write_w  <= 1'b0;
         r_rd_w         <= '0;
         r_result_src_w <= '0;
         r_funct3_w     <= '0;
         r_alu_result_w <= '0;
         r_read_data_w  <= '0;
         r_pc_plus4_w   <= '0;
         r_imm_ext_w    <= '0;
      end else if (!stall_w) begin
         r_valid_w      <= valid_m;
         r_reg_write_w  <= reg_write_m;
         r_rd_w         <= rd_m;
         r_result_src_w <= result_src_m;
         r_funct3_w     <= funct3_m;
         r_alu_result_w <= alu_result_m;
         r_read_data_w  <= read_data_m;
         r_pc_plus4_w   <= pc_plus4_m;
         r_imm_ext_w    <= imm_ext_m;
      end
   end

   // Byte lane from the full offset; halfword lane from offset bit 1 only.
   assign w_byte = r_read_data_w[{r_alu_result_w[1:0], 3'b000} +: 8];
   assign w_half = r_alu_result_w[1] ? r_read_data_w[31:16] : r_read_data_w[15:0];

   always_comb begin
      w_load_value = r_read_data_w;
      case (r_funct3_w)
         3'b000:  w_load_value = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
         3'b001:  w_load_value = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
         3'b100:  w_load_value = {{(DATA_WIDTH-8){1'b0}}, w_byte};
         3'b101:  w_load_value = {{(DATA_WIDTH-16){1'b0}}, w_half};
         default: w_load_value = r_read_data_w;
      endcase
   end

   always_comb begin
      wr_data = r_imm_ext_w;
      case (r_result_src_w)
         c_SRC_ALU:  wr_data = r_alu_result_w;
         c_SRC_LOAD: wr_data = w_load_value;
         c_SRC_PC4:  wr_data = r_pc_plus4_w;
         default:    wr_data = r_imm_ext_w;
      endcase
   end

   assign valid_w = r_valid_w;
   assign wr_en   = r_valid_w & r_reg_write_w & (r_rd_w != 5'd0);
   assign wr_addr = r_valid_w ? r_rd_w : 5'd0;

`ifdef MEM_WB_RETIRE_CNT_EN
   logic [63:0] r_instret;

   // An instruction retires on the edge it leaves W; flush still lets it go.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_instret <= '0;
      end else if (r_valid_w & (~stall_w | flush_w)) begin
         r_instret <= r_instret + 64'd1;
      end
   end

   assign instret = r_instret;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Purpose  : Scoreboard bench for mem_wb_stage against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall_w = 1'b0;
   logic        flush_w = 1'b0;
   logic        valid_m = 1'b0;
   logic        reg_write_m = 1'b0;
   logic [4:0]  rd_m = '0;
   logic [1:0]  result_src_m = '0;
   logic [2:0]  funct3_m = '0;
   logic [31:0] alu_result_m = '0;
   logic [31:0] read_data_m = '0;
   logic [31:0] pc_plus4_m = '0;
   logic [31:0] imm_ext_m = '0;
   logic        valid_w;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
`ifdef MEM_WB_RETIRE_CNT_EN
   logic [63:0] instret;
`endif

   int checks = 0;
   int errors = 0;

   mem_wb_stage #(.DATA_WIDTH(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall_w      (stall_w),
      .flush_w      (flush_w),
      .valid_m      (valid_m),
      .reg_write_m  (reg_write_m),
      .rd_m         (rd_m),
      .result_src_m (result_src_m),
      .funct3_m     (funct3_m),
      .alu_result_m (alu_result_m),
      .read_data_m  (read_data_m),
      .pc_plus4_m   (pc_plus4_m),
      .imm_ext_m    (imm_ext_m),
      .valid_w      (valid_w),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data)
`ifdef MEM_WB_RETIRE_CNT_EN
      ,
      .instret      (instret)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural model: the instruction currently held in W
   typedef struct {
      bit          valid;
      bit          regw;
      int unsigned rd;
      int unsigned src;
      int unsigned f3;
      int unsigned alu;
      int unsigned rdata;
      int unsigned pc;
      int unsigned imm;
   } instr_t;

   typedef struct {
      bit          v;
      bit          en;
      int unsigned addr;
      int unsigned data;
      longint unsigned cnt;
   } exp_t;

   instr_t          m_w;
   longint unsigned m_cnt = 0;
   exp_t            sb[$];

   function automatic int unsigned load_value(int unsigned f3, int unsigned off,
                                              int unsigned word);
      int unsigned b, h;
      b = (word >> (8 * off)) % 256;
      h = (word >> (16 * (off / 2))) % 65536;
      case (f3)
         0:       return (b >= 128) ? b + 32'hFFFFFF00 : b;
         4:       return b;
         1:       return (h >= 32768) ? h + 32'hFFFF0000 : h;
         5:       return h;
         default: return word;
      endcase
   endfunction

   function automatic exp_t expected(instr_t w, longint unsigned cnt);
      exp_t e;
      e.v    = w.valid;
      e.en   = w.valid && w.regw && (w.rd != 0);
      e.addr = w.valid ? w.rd : 0;
      case (w.src)
         0:       e.data = w.alu;
         1:       e.data = load_value(w.f3, w.alu % 4, w.rdata);
         2:       e.data = w.pc;
         default: e.data = w.imm;
      endcase
      e.cnt = cnt;
      return e;
   endfunction

   task automatic check(string name, longint unsigned act, longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply the model for one rising edge, queue the result, advance the clock.
   task automatic step();
      instr_t empty;
      empty = '{default: 0};
      if (reset) begin
         m_w   = empty;
         m_cnt = 0;
      end else begin
         if (m_w.valid && (!stall_w || flush_w)) m_cnt++;
         if (flush_w) begin
            m_w = empty;
         end else if (!stall_w) begin
            m_w.valid = valid_m;
            m_w.regw  = reg_write_m;
            m_w.rd    = rd_m;
            m_w.src   = result_src_m;
            m_w.f3    = funct3_m;
            m_w.alu   = alu_result_m;
            m_w.rdata = read_data_m;
            m_w.pc    = pc_plus4_m;
            m_w.imm   = imm_ext_m;
         end
      end
      sb.push_back(expected(m_w, m_cnt));
      @(posedge clk);
      #1;
   endtask

   task automatic drive(bit v, bit rw, int unsigned rd, int unsigned src,
                        int unsigned f3, int unsigned alu, int unsigned rdata,
                        int unsigned pc, int unsigned imm, bit st, bit fl);
      valid_m      = v;
      reg_write_m  = rw;
      rd_m         = rd[4:0];
      result_src_m = src[1:0];
      funct3_m     = f3[2:0];
      alu_result_m = alu;
      read_data_m  = rdata;
      pc_plus4_m   = pc;
      imm_ext_m    = imm;
      stall_w      = st;
      flush_w      = fl;
      step();
   endtask

   // Monitor: compares every presented W state against the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("valid_w", valid_w, e.v);
         check("wr_en",   wr_en,   e.en);
         check("wr_addr", wr_addr, e.addr);
         check("wr_data", wr_data, e.data);
`ifdef MEM_WB_RETIRE_CNT_EN
         check("instret", instret, e.cnt);
`endif
      end
   end

   initial begin
      m_w = '{default: 0};
      #1;
      check("reset_valid_w", valid_w, 0);
      check("reset_wr_en",   wr_en,   0);
      check("reset_wr_addr", wr_addr, 0);
      check("reset_wr_data", wr_data, 0);
      step();
      step();
      reset = 1'b0;

      // Write something, then assert reset asynchronously between edges
      drive(1, 1, 9, 0, 0, 32'h55, 0, 0, 0, 0, 0);
      check("pre_reset_wr_en", wr_en, 1);
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("async_reset_wr_en",   wr_en,   0);
      check("async_reset_valid_w", valid_w, 0);
      m_w = '{default: 0};
      m_cnt = 0;
      step();
      reset = 1'b0;

      drive(1, 1, 5, 0, 0, 32'h1234, 0, 0, 0, 0, 0);
      check("alu_wr_en",   wr_en,   1);
      check("alu_wr_addr", wr_addr, 5);
      check("alu_wr_data", wr_data, 32'h1234);

      // Load extension cases on 0x80FF7F01
      drive(1, 1, 3, 1, 0, 32'h1003, 32'h80FF7F01, 0, 0, 0, 0);
      check("lb_off3",  wr_data, 32'hFFFFFF80);
      drive(1, 1, 3, 1, 4, 32'h1003, 32'h80FF7F01, 0, 0, 0, 0);
      check("lbu_off3", wr_data, 32'h00000080);
      drive(1, 1, 3, 1, 0, 32'h1001, 32'h80FF7F01, 0, 0, 0, 0);
      check("lb_off1",  wr_data, 32'h0000007F);
      drive(1, 1, 3, 1, 1, 32'h1002, 32'h80FF7F01, 0, 0, 0, 0);
      check("lh_off2",  wr_data, 32'hFFFF80FF);
      drive(1, 1, 3, 1, 5, 32'h1000, 32'h80FF7F01, 0, 0, 0, 0);
      check("lhu_off0", wr_data, 32'h00007F01);
      drive(1, 1, 3, 1, 2, 32'h1002, 32'h80FF7F01, 0, 0, 0, 0);
      check("lw_off2",  wr_data, 32'h80FF7F01);

      // x0 suppression
      drive(1, 1, 0, 0, 0, 32'hDEAD, 0, 0, 0, 0, 0);
      check("x0_valid_w", valid_w, 1);
      check("x0_wr_en",   wr_en,   0);

      // Stall three cycles, then stall+flush
      drive(1, 1, 7, 2, 0, 0, 0, 32'h104, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 12, 0, 0, 32'h999, 0, 0, 0, 1, 0);
         check("stall_wr_en",   wr_en,   1);
         check("stall_wr_data", wr_data, 32'h104);
      end
      drive(1, 1, 12, 0, 0, 32'h999, 0, 0, 0, 1, 1);
      check("flush_valid_w", valid_w, 0);
      check("flush_wr_en",   wr_en,   0);

      // Immediate source and invalid slot
      drive(1, 1, 4, 3, 0, 0, 0, 0, 32'hABCDE000, 0, 0);
      check("imm_wr_data", wr_data, 32'hABCDE000);
      drive(0, 1, 4, 3, 0, 0, 0, 0, 32'hABCDE000, 0, 0);
      check("invalid_wr_en", wr_en, 0);

`ifdef MEM_WB_RETIRE_CNT_EN
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
      drive(1, 1, 2, 0, 0, 3, 0, 0, 0, 1, 0);
      drive(1, 1, 2, 0, 0, 3, 0, 0, 0, 0, 0);
      drive(1, 1, 3, 0, 0, 4, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("instret_four", instret, 4);

      @(negedge clk);
      #1;
      force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFE;
      #1;
      release dut.r_instret;
      m_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
      drive(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      check("instret_wrap", instret, 0);
`endif

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) < 8, $urandom_range(0, 1), $urandom_range(0, 31),
               $urandom_range(0, 3), $urandom_range(0, 7), $urandom, $urandom,
               $urandom, $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      end
      stall_w = 1'b0;
      flush_w = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
